// File: rtl/blk_smoother_if.sv
// Update/lookup port bundle of the per-block hysteresis smoother.
// master = block-stats / pixel side, slave = smoother.
interface blk_smoother_if #(
  parameter int HBLKS    = 64,
  parameter int VBLKS    = 36,
  parameter int SMOOTH_W = 6
);
  localparam int HW = $clog2(HBLKS);
  localparam int VW = $clog2(VBLKS);

  logic                flush_i;
  logic                upd_i;
  logic [HW-1:0]       upd_h_i;
  logic [VW-1:0]       upd_v_i;
  logic                upd_y_i;
  logic [HW-1:0]       rd_h_i;
  logic [VW-1:0]       rd_v_i;
  logic                rd_state_o;
  logic [SMOOTH_W-1:0] rd_cnt_o;
  logic                busy_o;
  logic                drop_o;

  modport master (
    output flush_i, upd_i, upd_h_i, upd_v_i, upd_y_i, rd_h_i, rd_v_i,
    input  rd_state_o, rd_cnt_o, busy_o, drop_o
  );
  modport slave (
    input  flush_i, upd_i, upd_h_i, upd_v_i, upd_y_i, rd_h_i, rd_v_i,
    output rd_state_o, rd_cnt_o, busy_o, drop_o
  );
endinterface

// File: rtl/blk_smoother.sv
// Per-block temporal hysteresis on the dark/light decision: saturating vote
// counter + sticky state per block, with a clear sweep and a 2-cycle lookup.
module blk_smoother #(
  parameter int HBLKS     = 64,
  parameter int VBLKS     = 36,
  parameter int SMOOTH_W  = 6,
  parameter int SMOOTH_HI = 40,
  parameter int SMOOTH_LO = 24
) (
  input logic           clk_i,
  input logic           rst_i,
  blk_smoother_if.slave bus
);
  localparam int HW    = $clog2(HBLKS);
  localparam int VW    = $clog2(VBLKS);
  localparam int DEPTH = HBLKS * VBLKS;
  localparam int AW    = $clog2(DEPTH);

  typedef struct packed {
    logic                state;
    logic [SMOOTH_W-1:0] cnt;
  } entry_t;

  localparam logic [SMOOTH_W-1:0] CMAX = '1;

  function automatic logic [AW-1:0] addr_of(logic [VW-1:0] v, logic [HW-1:0] h);
    return AW'(v) * AW'(HBLKS) + AW'(h);
  endfunction

  // Index ports that span a full power of two can never be out of range.
  logic uh_ok, uv_ok, rh_ok, rv_ok;
  if (HBLKS == (1 << HW)) begin : g_hfull
    assign uh_ok = 1'b1;
    assign rh_ok = 1'b1;
  end else begin : g_hchk
    assign uh_ok = bus.upd_h_i < HW'(HBLKS);
    assign rh_ok = bus.rd_h_i  < HW'(HBLKS);
  end
  if (VBLKS == (1 << VW)) begin : g_vfull
    assign uv_ok = 1'b1;
    assign rv_ok = 1'b1;
  end else begin : g_vchk
    assign uv_ok = bus.upd_v_i < VW'(VBLKS);
    assign rv_ok = bus.rd_v_i  < VW'(VBLKS);
  end

  entry_t        mem [DEPTH];
  logic          busy;
  logic [AW-1:0] sw_addr;

  logic [AW-1:0] u0_addr, rd_addr;
  logic          u0_acc;
  logic          u1_vld, u1_y, fwd_vld, drop;
  logic [AW-1:0] u1_addr;
  entry_t        ram_q, fwd_ent, u1_old, u1_new;
  entry_t        rd_q, rd_out;
  logic          rd_ok_q;

  assign u0_addr = (uh_ok && uv_ok) ? addr_of(bus.upd_v_i, bus.upd_h_i) : '0;
  assign rd_addr = (rh_ok && rv_ok) ? addr_of(bus.rd_v_i, bus.rd_h_i) : '0;
  assign u0_acc  = bus.upd_i && !busy && !bus.flush_i && uh_ok && uv_ok;

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) begin
      busy    <= 1'b1;
      sw_addr <= '0;
    end else if (busy) begin
      sw_addr <= sw_addr + AW'(1);
      if (sw_addr == AW'(DEPTH - 1)) busy <= 1'b0;
    end
  end

  // A back-to-back update to the same block takes U1's result, not the stale RAM word.
  always_comb begin
    u1_old = fwd_vld ? fwd_ent : ram_q;
    u1_new = u1_old;
    if (u1_y) begin
      if (u1_old.cnt != CMAX) u1_new.cnt = u1_old.cnt + SMOOTH_W'(1);
    end else if (u1_old.cnt != '0) begin
      u1_new.cnt = u1_old.cnt - SMOOTH_W'(1);
    end
    if (u1_new.cnt >= SMOOTH_W'(SMOOTH_HI))      u1_new.state = 1'b1;
    else if (u1_new.cnt <= SMOOTH_W'(SMOOTH_LO)) u1_new.state = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      u1_vld  <= 1'b0;
      fwd_vld <= 1'b0;
      drop    <= 1'b0;
      rd_ok_q <= 1'b0;
      rd_out  <= '0;
    end else begin
      u1_vld  <= u0_acc;
      fwd_vld <= u0_acc && u1_vld && (u0_addr == u1_addr);
      drop    <= bus.upd_i && !u0_acc;
      rd_ok_q <= rh_ok && rv_ok && !busy;
      rd_out  <= rd_ok_q ? rd_q : '0;
    end
    u1_addr <= u0_addr;
    u1_y    <= bus.upd_y_i;
    fwd_ent <= u1_new;
  end

  // Single write port: sweep and update writes never coincide since updates are refused while busy.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (busy)        mem[sw_addr] <= '0;
      else if (u1_vld) mem[u1_addr] <= u1_new;
    end
    ram_q <= mem[u0_addr];
    rd_q  <= mem[rd_addr];
  end

  assign bus.busy_o     = busy;
  assign bus.drop_o     = drop;
  assign bus.rd_state_o = rd_out.state;
  assign bus.rd_cnt_o   = rd_out.cnt;
endmodule

// File: tb/tb_blk_smoother.sv
// Bench for blk_smoother: array-based reference model checked every cycle,
// directed scenarios with literal expectations, then biased random traffic.
module tb_blk_smoother;
  localparam int HB = 64, VB = 36, W = 6, HI = 40, LO = 24;
  localparam int N  = HB * VB;
  localparam int CM = (1 << W) - 1;
  localparam int HW = $clog2(HB), VW = $clog2(VB);

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  blk_smoother_if #(.HBLKS(HB), .VBLKS(VB), .SMOOTH_W(W)) bus ();
  blk_smoother #(.HBLKS(HB), .VBLKS(VB), .SMOOTH_W(W), .SMOOTH_HI(HI), .SMOOTH_LO(LO))
    dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  int vectors = 0, miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int  mcnt [N];
  bit  mst  [N];
  int  busy_left = 0;
  bit  armed = 0;
  bit  exp_busy, exp_drop, exp_st, pipe_st;
  int  exp_cnt, pipe_cnt;
  bit  pend_vld = 0, pend_y;
  int  pend_a;

  function automatic void step(int a, bit y);
    if (y) mcnt[a] = (mcnt[a] == CM) ? CM : mcnt[a] + 1;
    else   mcnt[a] = (mcnt[a] == 0)  ? 0  : mcnt[a] - 1;
    if (mcnt[a] >= HI)      mst[a] = 1'b1;
    else if (mcnt[a] <= LO) mst[a] = 1'b0;
  endfunction

  // A lookup sees every update accepted two or more cycles earlier; the update
  // of the previous cycle is committed only after this cycle's lookup is taken.
  always @(posedge clk_i) begin : model
    bit bnow, ok_up, acc;
    bnow = busy_left > 0;
    exp_cnt = pipe_cnt;
    exp_st  = pipe_st;
    if (!bnow && int'(bus.rd_h_i) < HB && int'(bus.rd_v_i) < VB) begin
      pipe_cnt = mcnt[int'(bus.rd_v_i) * HB + int'(bus.rd_h_i)];
      pipe_st  = mst [int'(bus.rd_v_i) * HB + int'(bus.rd_h_i)];
    end else begin
      pipe_cnt = 0;
      pipe_st  = 0;
    end
    if (pend_vld && !rst_i) step(pend_a, pend_y);
    pend_vld = 0;
    ok_up = int'(bus.upd_h_i) < HB && int'(bus.upd_v_i) < VB;
    acc   = bus.upd_i && ok_up && !bnow && !bus.flush_i && !rst_i;
    exp_drop = !rst_i && bus.upd_i && !acc;
    if (acc) begin
      pend_vld = 1;
      pend_a   = int'(bus.upd_v_i) * HB + int'(bus.upd_h_i);
      pend_y   = bus.upd_y_i;
    end
    if (rst_i || bus.flush_i) begin
      foreach (mcnt[i]) begin mcnt[i] = 0; mst[i] = 0; end
      busy_left = N;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    if (rst_i) begin
      exp_cnt = 0; exp_st = 0; pipe_cnt = 0; pipe_st = 0;
      armed = 1;
    end
    exp_busy = busy_left > 0;
  end

  always @(negedge clk_i) begin
    if (armed) begin
      chk("busy_o",     32'(bus.busy_o),     32'(exp_busy));
      chk("drop_o",     32'(bus.drop_o),     32'(exp_drop));
      chk("rd_cnt_o",   32'(bus.rd_cnt_o),   32'(exp_cnt));
      chk("rd_state_o", 32'(bus.rd_state_o), 32'(exp_st));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic upd(input int h, input int v, input bit y, input int gap);
    bus.upd_i = 1; bus.upd_h_i = HW'(h); bus.upd_v_i = VW'(v); bus.upd_y_i = y;
    tick();
    bus.upd_i = 0;
    repeat (gap) tick();
  endtask

  task automatic check_blk(input string nm, input int h, input int v, input int est, input int ec);
    bus.rd_h_i = HW'(h); bus.rd_v_i = VW'(v);
    tick(); tick();
    chk({nm, "_state"}, 32'(bus.rd_state_o), 32'(est));
    chk({nm, "_cnt"},   32'(bus.rd_cnt_o),   32'(ec));
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (bus.busy_o !== 1'b0 && n < 5000) begin tick(); n++; end
    chk({nm, "_sweep_end"}, 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    int n;
    rst_i = 1; bus.flush_i = 0; bus.upd_i = 0; bus.upd_h_i = '0; bus.upd_v_i = '0;
    bus.upd_y_i = 0; bus.rd_h_i = '0; bus.rd_v_i = '0;
    tick();
    rst_i = 0;

    // reset sweep length
    n = 0;
    while (bus.busy_o === 1'b1 && n < 3000) begin n++; tick(); end
    chk("reset_busy_len", 32'(n), 32'(N));
    chk("reset_drop", 32'(bus.drop_o), 32'd0);
    check_blk("reset_last", 63, 35, 0, 0);

    // hysteresis
    repeat (39) upd(3, 2, 1, 1);
    check_blk("hyst39", 3, 2, 0, 39);
    upd(3, 2, 1, 1);
    check_blk("hyst40", 3, 2, 1, 40);
    repeat (15) upd(3, 2, 0, 1);
    check_blk("hyst25", 3, 2, 1, 25);
    upd(3, 2, 0, 1);
    check_blk("hyst24", 3, 2, 0, 24);

    // saturation (back-to-back, so the forward path carries the count)
    repeat (70) upd(0, 0, 1, 0);
    tick();
    check_blk("sat_hi", 0, 0, 1, 63);
    upd(0, 0, 0, 1);
    check_blk("sat_dec", 0, 0, 1, 62);
    upd(10, 10, 0, 1);
    check_blk("sat_lo", 10, 10, 0, 0);

    // forwarding
    repeat (10) upd(5, 5, 1, 1);
    upd(5, 5, 1, 0); upd(5, 5, 1, 0); upd(5, 5, 1, 1);
    check_blk("fwd_inc3", 5, 5, 0, 13);
    repeat (10) upd(5, 6, 1, 1);
    upd(5, 6, 1, 0); upd(5, 6, 0, 0); upd(5, 6, 1, 1);
    check_blk("fwd_alt", 5, 6, 0, 11);

    // collision: lookup N+1 sees old, N+2 sees new
    repeat (20) upd(7, 1, 1, 1);
    bus.upd_i = 1; bus.upd_h_i = HW'(7); bus.upd_v_i = VW'(1); bus.upd_y_i = 1;
    tick();
    bus.upd_i = 0; bus.rd_h_i = HW'(7); bus.rd_v_i = VW'(1);
    tick(); tick();
    chk("coll_old", 32'(bus.rd_cnt_o), 32'd20);
    tick();
    chk("coll_new", 32'(bus.rd_cnt_o), 32'd21);

    // drops: out-of-range row, then update during a flush sweep
    upd(3, 36, 1, 0);
    chk("drop_oor", 32'(bus.drop_o), 32'd1);
    tick();
    chk("drop_oor_end", 32'(bus.drop_o), 32'd0);
    check_blk("drop_keep", 3, 2, 0, 24);
    check_blk("rd_oor", 3, 37, 0, 0);
    bus.flush_i = 1;
    tick();
    bus.flush_i = 0;
    repeat (4) tick();
    upd(3, 2, 1, 0);
    chk("drop_busy", 32'(bus.drop_o), 32'd1);
    chk("busy_flush", 32'(bus.busy_o), 32'd1);
    wait_idle("flush");
    check_blk("flush_clr", 3, 2, 0, 0);

    // biased random traffic over a few blocks, with a flush and a reset thrown in
    for (int p = 0; p < 4; p++) begin
      int bias;
      bias = (p == 0) ? 7 : (p == 1) ? 1 : (p == 2) ? 4 : 6;
      for (int i = 0; i < 2000; i++) begin
        bus.upd_i   = ($urandom_range(0, 3) != 0);
        bus.upd_h_i = HW'($urandom_range(0, 2));
        bus.upd_v_i = ($urandom_range(0, 40) == 0) ? VW'(36 + $urandom_range(0, 3))
                                                   : VW'($urandom_range(0, 1));
        bus.upd_y_i = ($urandom_range(0, 7) < bias);
        bus.rd_h_i  = HW'($urandom_range(0, 2));
        bus.rd_v_i  = ($urandom_range(0, 30) == 0) ? VW'(37) : VW'($urandom_range(0, 1));
        bus.flush_i = (p == 2 && i == 1000);
        rst_i       = (p == 3 && i == 500);
        tick();
      end
    end
    bus.upd_i = 0; bus.flush_i = 0; rst_i = 0;
    wait_idle("final");
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
